// File: rtl/jk_bank_pkg.sv
// Shared constants for the JK bank arbiter: {j,k} opcodes, FSM encoding, requester ids.
// Helper functions split an opcode into its j and k components.
package jk_bank_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  function automatic logic op_j(input logic [1:0] op);
    return (op == OP_SET) || (op == OP_TGL);
  endfunction

  function automatic logic op_k(input logic [1:0] op);
    return (op == OP_CLR) || (op == OP_TGL);
  endfunction

endpackage

// File: rtl/jk_bank.sv
// Bank of WIDTH independent JK flip-flops with synchronous active-high reset.
module jk_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  // Per-bit JK characteristic: q+ = j & ~q | ~k & q.
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= (j & ~q) | (~k & q);
  end

  assign q_bar = ~q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter between requesters A and B; the granted command drives
// the JK bank's J/K inputs for its repeat count, then pulses done.
module jk_bank_arbiter
  import jk_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [1:0]       a_op,
  input  logic [WIDTH-1:0] a_mask,
  input  logic [CW-1:0]    a_cnt,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [1:0]       b_op,
  input  logic [WIDTH-1:0] b_mask,
  input  logic [CW-1:0]    b_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             busy,
  output logic             done,
  output logic             grant_id
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e           state, state_next;
  logic             rr_last;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic [CW-1:0]    rem;
  logic             pick_b;
  logic             hs;
  logic [WIDTH-1:0] j, k;
  logic [CW-1:0]    sel_cnt;

  // Handshake: a command transfers at a rising edge where valid and ready are
  // both high; ready is only offered in IDLE, to one requester, never in reset.
  always_comb begin
    pick_b     = b_valid && (!a_valid || (rr_last == REQ_A));
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    j          = '0;
    k          = '0;
    state_next = state;
    case (state)
      ST_IDLE: begin
        a_ready = !rst && a_valid && !pick_b;
        b_ready = !rst && pick_b;
        if (a_ready || b_ready) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        j = mask_r & {WIDTH{op_j(op_r)}};
        k = mask_r & {WIDTH{op_k(op_r)}};
        if (rem == CNT_ONE) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign hs      = a_ready || b_ready;
  assign sel_cnt = pick_b ? b_cnt : a_cnt;
  assign busy    = (state == ST_EXEC);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // rr_last resets to B so that A wins the first contended arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last  <= REQ_B;
      grant_id <= REQ_A;
      op_r     <= OP_HOLD;
      mask_r   <= '0;
      rem      <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == ST_EXEC) && (rem == CNT_ONE);
      if (hs) begin
        rr_last  <= pick_b;
        grant_id <= pick_b;
        op_r     <= pick_b ? b_op   : a_op;
        mask_r   <= pick_b ? b_mask : a_mask;
        rem      <= (sel_cnt == '0) ? CNT_ONE : sel_cnt;
      end else if (state == ST_EXEC) begin
        rem <= rem - CNT_ONE;
      end
    end
  end

  jk_bank #(.WIDTH(WIDTH)) u_bank (
    .clk   (clk),
    .rst   (rst),
    .j     (j),
    .k     (k),
    .q     (q),
    .q_bar (q_bar)
  );

endmodule
